// File: rtl/cmp_stream_minmax_if.sv
// Sample-in / result-out handshake bundle for cmp_stream_minmax.
// slave = the min/max block, master = the sample producer and result consumer.
interface cmp_stream_minmax_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_max;
    logic [N-1:0]     out_min;
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_min_idx;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_min,
               out_max_idx, out_min_idx, out_count, out_ovf
    );
endinterface

// File: rtl/cmp_stream_minmax.sv
// Running max/min (with first-occurrence indices) over a sample burst using one shared external comparator.
// Latency: first sample 1 cycle, later samples 3 cycles; record valid 1 cycle after the last compare.
// Backpressure: in_ready low while comparing or holding a result; the result is held until out_ready.
module cmp_stream_minmax #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_stream_minmax_if.slave s,
    output logic [N-1:0]      cmp_num1,
    output logic [N-1:0]      cmp_num2,
    input  logic [N-1:0]      cmp_g,
    input  logic [N-1:0]      cmp_e,
    input  logic [N-1:0]      cmp_l
);
    typedef enum logic [1:0] {IDLE, CMP_MAX, CMP_MIN, OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t           state;
    logic             first;
    logic             rdy_q;
    logic [N-1:0]     max_q, min_q, hold_q;
    logic             hold_last_q;
    logic [CNT_W-1:0] max_idx_q, min_idx_q, count_q;
    logic             ovf_q;

    // Only bit 0 of each comparator flag carries information; e is not needed at all.
    logic unused_cmp_bits;
    assign unused_cmp_bits = ^{cmp_e, cmp_g[N-1:1], cmp_l[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            first       <= 1'b1;
            rdy_q       <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s.in_valid && rdy_q) begin
                        if (first) begin
                            max_q     <= s.in_data;
                            min_q     <= s.in_data;
                            max_idx_q <= '0;
                            min_idx_q <= '0;
                            count_q   <= CNT_W'(1);
                            first     <= 1'b0;
                            if (s.in_last) begin
                                state <= OUT;
                                rdy_q <= 1'b0;
                            end
                        end else begin
                            hold_q      <= s.in_data;
                            hold_last_q <= s.in_last;
                            state       <= CMP_MAX;
                            rdy_q       <= 1'b0;
                        end
                    end else begin
                        // Raises ready on the first cycle after reset release.
                        rdy_q <= 1'b1;
                    end
                end
                CMP_MAX: begin
                    if (cmp_g[0]) begin
                        max_q     <= hold_q;
                        max_idx_q <= count_q;
                    end
                    state <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (cmp_l[0]) begin
                        min_q     <= hold_q;
                        min_idx_q <= count_q;
                    end
                    if (count_q == CNT_SAT) ovf_q <= 1'b1;
                    else                    count_q <= count_q + CNT_W'(1);
                    if (hold_last_q) begin
                        state <= OUT;
                    end else begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (s.out_ready) begin
                        state <= IDLE;
                        first <= 1'b1;
                        ovf_q <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cmp_num1 = '0;
        cmp_num2 = '0;
        case (state)
            CMP_MAX: begin
                cmp_num1 = hold_q;
                cmp_num2 = max_q;
            end
            CMP_MIN: begin
                cmp_num1 = hold_q;
                cmp_num2 = min_q;
            end
            default: ;
        endcase
    end

    assign s.in_ready    = rdy_q;
    assign s.out_valid   = (state == OUT);
    assign s.out_max     = max_q;
    assign s.out_min     = min_q;
    assign s.out_max_idx = max_idx_q;
    assign s.out_min_idx = min_idx_q;
    assign s.out_count   = count_q;
    assign s.out_ovf     = ovf_q;
endmodule

// File: tb/tb_cmp_stream_minmax.sv
// Directed bench for cmp_stream_minmax: one CNT_W=8 instance and one CNT_W=2 instance,
// each wired to a behavioural unsigned comparator.
module tb_cmp_stream_minmax;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        lst = 1'b0;
    logic        ordy = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] dat = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int acc1, acc2, acc3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_stream_minmax_if #(.N(32), .CNT_W(8)) ifa ();
    cmp_stream_minmax_if #(.N(32), .CNT_W(2)) ifb ();

    logic [31:0] a_num1, a_num2, a_g, a_e, a_l;
    logic [31:0] b_num1, b_num2, b_g, b_e, b_l;

    assign a_g = {31'b0, a_num1 >  a_num2};
    assign a_e = {31'b0, a_num1 == a_num2};
    assign a_l = {31'b0, a_num1 <  a_num2};
    assign b_g = {31'b0, b_num1 >  b_num2};
    assign b_e = {31'b0, b_num1 == b_num2};
    assign b_l = {31'b0, b_num1 <  b_num2};

    assign ifa.in_valid  = vld & ~sel;
    assign ifa.in_data   = dat;
    assign ifa.in_last   = lst;
    assign ifa.out_ready = ordy & ~sel;
    assign ifb.in_valid  = vld & sel;
    assign ifb.in_data   = dat;
    assign ifb.in_last   = lst;
    assign ifb.out_ready = ordy & sel;

    cmp_stream_minmax #(.N(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ifa.slave),
        .cmp_num1(a_num1), .cmp_num2(a_num2),
        .cmp_g(a_g), .cmp_e(a_e), .cmp_l(a_l)
    );

    cmp_stream_minmax #(.N(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ifb.slave),
        .cmp_num1(b_num1), .cmp_num2(b_num2),
        .cmp_g(b_g), .cmp_e(b_e), .cmp_l(b_l)
    );

    wire        rdy  = sel ? ifb.in_ready  : ifa.in_ready;
    wire        ov   = sel ? ifb.out_valid : ifa.out_valid;
    wire [31:0] omax = sel ? ifb.out_max   : ifa.out_max;
    wire [31:0] omin = sel ? ifb.out_min   : ifa.out_min;
    wire [7:0]  omxi = sel ? {6'b0, ifb.out_max_idx} : ifa.out_max_idx;
    wire [7:0]  omni = sel ? {6'b0, ifb.out_min_idx} : ifa.out_min_idx;
    wire [7:0]  ocnt = sel ? {6'b0, ifb.out_count}   : ifa.out_count;
    wire        oovf = sel ? ifb.out_ovf   : ifa.out_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        while (rdy !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (rdy !== 1'b1) check("in_ready_timeout", rdy, 1);
        vld = 1'b1; dat = d; lst = last;
        @(posedge clk); #1;
        acc = cyc;
        vld = 1'b0; lst = 1'b0; dat = 32'hDEAD_BEEF;
    endtask

    task automatic wait_out();
        int t = 0;
        while (ov !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (ov !== 1'b1) check("out_valid_timeout", ov, 1);
    endtask

    task automatic check_rec(input string tag, input logic [31:0] mx, input logic [31:0] mn,
                             input logic [7:0] mxi, input logic [7:0] mni,
                             input logic [7:0] cnt, input logic ovf);
        check({tag, "_max"},     omax, mx);
        check({tag, "_min"},     omin, mn);
        check({tag, "_max_idx"}, omxi, mxi);
        check({tag, "_min_idx"}, omni, mni);
        check({tag, "_count"},   ocnt, cnt);
        check({tag, "_ovf"},     oovf, ovf);
    endtask

    task automatic release_out(input string tag);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check({tag, "_valid_drop"}, ov, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready",  ifa.in_ready, 0);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_max",   ifa.out_max, 0);
        check("rst_cmp_num1",  a_num1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-sample burst
        send(32'h0000_0007, 1'b1);
        check("single_valid_next", ov, 1);
        check_rec("single", 32'd7, 32'd7, 8'd0, 8'd0, 8'd1, 1'b0);
        release_out("single");

        // Burst 5,9,2,9,2 with accept spacing
        send(32'd5, 1'b0); acc1 = acc;
        send(32'd9, 1'b0); acc2 = acc;
        send(32'd2, 1'b0); acc3 = acc;
        check("spacing_first", acc2 - acc1, 1);
        check("spacing_later", acc3 - acc2, 3);
        send(32'd9, 1'b0);
        send(32'd2, 1'b1);
        check("burst5_no_valid_yet", ov, 0);
        @(posedge clk); #1;
        check("burst5_no_valid_cmp", ov, 0);
        @(posedge clk); #1;
        check("burst5_valid_after_cmp", ov, 1);
        check_rec("burst5", 32'd9, 32'd2, 8'd1, 8'd2, 8'd5, 1'b0);
        release_out("burst5");

        // Unsigned extremes, then hold the record under backpressure
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h8000_0000, 1'b1);
        wait_out();
        check_rec("unsigned", 32'hFFFF_FFFF, 32'h0, 8'd0, 8'd1, 8'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", ov, 1);
            check("hold_in_ready", rdy, 0);
            check("hold_max", omax, 32'hFFFF_FFFF);
            check("hold_min_idx", omni, 8'd1);
        end
        release_out("unsigned");

        // Next burst restarts indices
        send(32'd4, 1'b0);
        send(32'd6, 1'b1);
        wait_out();
        check_rec("restart", 32'd6, 32'd4, 8'd1, 8'd0, 8'd2, 1'b0);
        release_out("restart");

        // Narrow counter: saturation and sticky overflow
        sel = 1'b1;
        @(posedge clk); #1;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        send(32'd0, 1'b1);
        wait_out();
        check_rec("sat", 32'd4, 32'd0, 8'd3, 8'd3, 8'd3, 1'b1);
        release_out("sat");
        check("sat_ovf_cleared", oovf, 0);
        sel = 1'b0;

        // Reset during CMP_MIN of the third sample
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd5, 1'b0);
        @(posedge clk); #1;
        check("midrst_in_cmp_min", a_num2, 32'd10);
        rst_n = 1'b0;
        #1;
        check("midrst_max",      ifa.out_max, 0);
        check("midrst_min",      ifa.out_min, 0);
        check("midrst_count",    ifa.out_count, 0);
        check("midrst_valid",    ifa.out_valid, 0);
        check("midrst_in_ready", ifa.in_ready, 0);
        check("midrst_cmp_num1", a_num1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'd3, 1'b0);
        send(32'd3, 1'b1);
        wait_out();
        check_rec("fresh", 32'd3, 32'd3, 8'd0, 8'd0, 8'd2, 1'b0);
        release_out("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_stream_minmax.md
Name: cmp_stream_minmax

Overview:
- Sequential front/back-end for the 32-bit magnitude comparator.
- Accepts a burst of unsigned samples over a valid/ready handshake.
- Time-shares one external comparator instance: drives its num1/num2 inputs and consumes its g/e/l outputs to track the running maximum, minimum and their indices.
- Presents one result record per burst on an output handshake.

Parameters:
- N, 32, sample width; must match the attached comparator's N.
- CNT_W, 8, width of the sample counter and index fields.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  N  unsigned sample.
- in_last  input  1  marks the final sample of a burst; qualified by in_valid.
- cmp_num1  output  N  to comparator num1.
- cmp_num2  output  N  to comparator num2.
- cmp_g  input  N  comparator g; only bit 0 is meaningful.
- cmp_e  input  N  comparator e; only bit 0 is meaningful; ignored by this block.
- cmp_l  input  N  comparator l; only bit 0 is meaningful.
- out_valid  output  1  result record valid.
- out_ready  input  1  consumer accepts the record.
- out_max  output  N  largest sample in the burst.
- out_min  output  N  smallest sample in the burst.
- out_max_idx  output  CNT_W  index (0-based) of the first occurrence of the max.
- out_min_idx  output  CNT_W  index of the first occurrence of the min.
- out_count  output  CNT_W  samples in the burst, saturating.
- out_ovf  output  1  burst length exceeded 2^CNT_W-1.

Behaviour:
- Reset (async assert, sync deassert on clk) sets:
  - state=IDLE, first=1.
  - All registers, out_* and cmp_num* to 0; in_ready=0 while rst_n=0.
- FSM states: IDLE, CMP_MAX, CMP_MIN, OUT.
- IDLE:
  - in_ready=1. A sample is accepted when in_valid&in_ready.
  - If first=1: max=min=in_data, max_idx=min_idx=0, count=1, first<=0. Go to OUT if in_last, else stay in IDLE.
  - If first=0: hold<=in_data, hold_last<=in_last, go to CMP_MAX.
- CMP_MAX:
  - in_ready=0; cmp_num1=hold, cmp_num2=max.
  - If cmp_g[0]: max<=hold, max_idx<=count.
  - Go to CMP_MIN.
- CMP_MIN:
  - in_ready=0; cmp_num1=hold, cmp_num2=min.
  - If cmp_l[0]: min<=hold, min_idx<=count.
  - count<=count+1, saturating at 2^CNT_W-1. An increment attempted at saturation sets ovf, which is sticky until the burst ends.
  - Go to OUT if hold_last, else IDLE.
- OUT:
  - out_valid=1; out_* are stable registered values; in_ready=0.
  - On out_ready: out_valid falls the next cycle, first<=1, ovf<=0, go to IDLE.
  - out_valid must not drop without out_ready.
- cmp_num1/cmp_num2 are registered/muxed from the state only, and are 0 in IDLE and OUT.
- The comparator is combinational; its flags are sampled in the same cycle as cmp_num* are driven.
- Timing:
  - The first sample of a burst costs 1 cycle; each later sample costs 3 cycles (accept + 2 compares).
  - Earliest out_valid is 1 cycle after the last sample's final compare.
- Ties: equal samples never replace max/min, so the indices report the first occurrence.
- Once saturated, indices keep using the saturated count value.
- Width rules: comparison is unsigned, per the comparator. The block never inspects cmp_* bits above bit 0.
- in_last on a single-sample burst: go directly to OUT with max=min=sample and count=1.
- Reset mid-burst or while in OUT: partial results are discarded and the block returns to the post-reset state; no record is emitted.
- in_data/in_last are don't-care when in_valid=0.

Test Plan:
- Single sample 0x0000_0007 with in_last=1 -> out_valid the next cycle; max=min=7, idx 0/0, count=1, ovf=0.
- Burst 5, 9, 2, 9, 2 (last on the 5th) -> max=9 idx=1, min=2 idx=2, count=5; accept-to-accept spacing of 3 cycles after the first sample.
- Burst 0xFFFF_FFFF, 0, 0x8000_0000 -> max=0xFFFF_FFFF idx0, min=0 idx1; confirms unsigned comparison through the external comparator model.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid and out_* stable and in_ready=0; release -> IDLE, and the next burst restarts its indices at 0.
- CNT_W=2, burst of 5 samples 1, 2, 3, 4, 0 -> count=3, ovf=1, max=4 idx=3 (saturated), min=0 idx=3.
- Assert rst_n=0 during CMP_MIN of the 3rd sample -> all outputs 0 immediately; a fresh burst afterwards yields correct results with no residue.
